// File: rtl/pmod_pkg.sv
// Shared definitions for the PMOD ADC reader and its DAC serializer companion:
// frame geometry and the serial-frame state machine encoding.
package pmod_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    QUIET
  } pmod_state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_BITS  = FRAME_BITS - DATA_BITS;

endpackage

// File: rtl/pmod_clk_div.sv
// N-cycle tick generator. tick is high on every Nth clock edge after the
// last restart; restart forces the count back to zero so each FSM state
// begins with a full N-cycle interval.
module pmod_clk_div
  import pmod_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(N - 1));

  // Count 0..N-1, wrapping on tick and clearing on restart.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pmod_ad_rx.sv
// Frame reader for a 12-bit serial ADC PMOD. Drives cs and a divided sclk,
// shifts sdata in MSB-first on sclk rising edges and presents the 12 payload
// bits with a one-cycle dout_valid. The four leading bits should be zero;
// a nonzero lead bit is flagged on frame_err but the sample is still used.
module pmod_ad_rx
  import pmod_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = pmod_pkg::FRAME_BITS,
  parameter int DATA_BITS  = pmod_pkg::DATA_BITS,
  parameter int QUIET_CLKS = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 sdata,
  output logic                 cs,
  output logic                 sclk,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int QW = (QUIET_CLKS > 1) ? $clog2(QUIET_CLKS) : 1;

  pmod_state_e         state, state_n;
  logic [4:0]          bitcnt, bitcnt_n;
  logic [QW-1:0]       qcnt;
  logic                qdone;
  logic                tick, restart;
  logic                cs_n, sclk_n, busy_n, valid_n;
  logic                capture, publish;
  logic [FRAME_BITS-1:0] shreg;

  // The divider restarts whenever the FSM changes state (and idles in reset
  // while in IDLE) so SETUP, SHIFT and HOLD each start a fresh half-period.
  assign restart = (state_n != state) || (state == IDLE);
  assign qdone   = (qcnt == QW'(QUIET_CLKS - 1));

  pmod_clk_div #(.N(CLK_DIV)) u_div (
    .clock   (clock),
    .resetn  (resetn),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    cs_n     = cs;
    sclk_n   = sclk;
    valid_n  = 1'b0;
    capture  = 1'b0;
    publish  = 1'b0;
    case (state)
      IDLE: begin
        cs_n   = 1'b1;
        sclk_n = 1'b1;
        if (start || continuous) begin
          state_n  = SETUP;
          cs_n     = 1'b0;
          bitcnt_n = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_n  = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk) begin
            sclk_n = 1'b0;
          end else begin
            // Rising edge: the ADC bit has had a full half-period to settle.
            sclk_n  = 1'b1;
            capture = 1'b1;
            if (bitcnt == 5'(FRAME_BITS - 1)) begin
              state_n = HOLD;
            end else begin
              bitcnt_n = bitcnt + 5'd1;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n    = 1'b1;
          valid_n = 1'b1;
          publish = 1'b1;
          state_n = QUIET;
        end
      end
      QUIET: begin
        if (qdone) begin
          if (continuous) begin
            state_n  = SETUP;
            cs_n     = 1'b0;
            bitcnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cs_n    = 1'b1;
        sclk_n  = 1'b1;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered control outputs; reset forces cs/sclk high at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      bitcnt     <= '0;
      cs         <= 1'b1;
      sclk       <= 1'b1;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      bitcnt     <= bitcnt_n;
      cs         <= cs_n;
      sclk       <= sclk_n;
      busy       <= busy_n;
      dout_valid <= valid_n;
    end
  end

  // Cycle counter for the cs-high gap between frames.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      qcnt <= '0;
    end else if (state != QUIET) begin
      qcnt <= '0;
    end else begin
      qcnt <= qcnt + QW'(1);
    end
  end

  // Frame shift register, MSB arrives first.
  always_ff @(posedge clock) begin
    if (capture) begin
      shreg <= {shreg[FRAME_BITS-2:0], sdata};
    end
  end

  // Sample output registers; only a completed frame ever updates them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout      <= '0;
      frame_err <= 1'b0;
    end else if (publish) begin
      dout      <= shreg[DATA_BITS-1:0];
      frame_err <= |shreg[FRAME_BITS-1:DATA_BITS];
    end
  end

endmodule

// File: tb/tb_pmod_ad_rx.sv
// Bench for pmod_ad_rx: a behavioural ADC drives frame bits on sclk falls,
// each frame start pushes the expected sample into a scoreboard, and a
// monitor compares every dout_valid against it.
module tb_pmod_ad_rx;

  localparam int N = 2;
  localparam int Q = 8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        sdata = 1'b0;
  logic        cs, sclk, dout_valid, frame_err, busy;
  logic [11:0] dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] d;
    logic        e;
    int          t;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] adc_q[$];
  logic [15:0] cur_frame = 16'h0;
  int          bitidx = 0;
  int          rises = 0;
  int          frames = 0;
  int          cyc = 0;
  int          cs_hi = 0;
  int          sclk_edges = 0;
  logic        cs_prev = 1'bx;
  logic        busy_prev = 1'bx;

  pmod_ad_rx #(.CLK_DIV(N), .QUIET_CLKS(Q)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .continuous (continuous),
    .sdata      (sdata),
    .cs         (cs),
    .sclk       (sclk),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ADC model: shift the next frame bit out after every sclk fall.
  always @(negedge sclk) begin
    chk("cs_low_at_sclk_fall", {31'd0, cs}, 32'd0);
    if (cs === 1'b0) begin
      if (bitidx < 16) sdata = cur_frame[15 - bitidx];
      bitidx++;
    end
  end

  always @(posedge sclk) if (cs === 1'b0) rises++;
  always @(sclk) sclk_edges++;

  // Frame-start detection feeds the scoreboard; dout_valid pops and compares.
  always @(negedge clock) begin
    exp_t e;
    if (cs_prev === 1'b1 && cs === 1'b0) begin
      if (busy_prev === 1'b1) chk("quiet_len", cs_hi, Q);
      frames++;
      rises  = 0;
      bitidx = 0;
      cur_frame = (adc_q.size() > 0) ? adc_q.pop_front() : 16'($urandom);
      sb.push_back('{cur_frame[11:0], |cur_frame[15:12], cyc + 33 * N});
    end
    cs_hi = (cs === 1'b1) ? cs_hi + 1 : 0;
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dout", {20'd0, dout}, {20'd0, e.d});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.e});
        chk("latency", cyc, e.t);
        chk("sclk_rises", rises, 16);
      end
    end
    cs_prev   = cs;
    busy_prev = busy;
  end

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (dout_valid === 1'b1) seen = 1;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clock);
      if (busy === 1'b0) idle = 1;
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  task automatic single_shot(input logic [15:0] f);
    int f0;
    f0 = frames;
    adc_q.push_back(f);
    pulse_start();
    chk("cs_after_start", {31'd0, cs}, 0);
    chk("busy_after_start", {31'd0, busy}, 1);
    wait_valid(200);
    repeat (7) @(negedge clock);
    chk("busy_in_quiet", {31'd0, busy}, 1);
    @(negedge clock);
    chk("busy_after_quiet", {31'd0, busy}, 0);
    chk("one_frame", frames - f0, 1);
  endtask

  initial begin
    int f0, n0;
    bit hit;

    // Reset state and no sclk activity while held.
    repeat (3) @(negedge clock);
    n0 = sclk_edges;
    repeat (5) @(negedge clock);
    chk("rst_cs", {31'd0, cs}, 1);
    chk("rst_sclk", {31'd0, sclk}, 1);
    chk("rst_dout", {20'd0, dout}, 0);
    chk("rst_valid", {31'd0, dout_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ferr", {31'd0, frame_err}, 0);
    chk("rst_sclk_quiet", sclk_edges - n0, 0);
    @(negedge clock) resetn = 1'b1;
    repeat (3) @(negedge clock);

    single_shot(16'h0ABC);
    single_shot(16'h8123);
    for (int i = 0; i < 5; i++) single_shot(16'($urandom));

    // Start while busy is ignored.
    f0 = frames;
    adc_q.push_back(16'($urandom) & 16'h0FFF);
    pulse_start();
    repeat (19) @(negedge clock);
    pulse_start();
    wait_valid(200);
    wait_idle(50);
    repeat (80) @(negedge clock);
    chk("busy_start_ignored", frames - f0, 1);

    // Continuous mode, dropped during the third frame.
    f0 = frames;
    adc_q.push_back(16'h0FFF);
    adc_q.push_back(16'h0000);
    adc_q.push_back(16'h0555);
    @(negedge clock) continuous = 1'b1;
    wait_valid(200);
    wait_valid(200);
    repeat (30) @(negedge clock);
    continuous = 1'b0;
    wait_valid(200);
    wait_idle(50);
    repeat (80) @(negedge clock);
    chk("cont_frames", frames - f0, 3);

    // Asynchronous reset after the 7th sclk rise discards the frame.
    adc_q.push_back(16'h0F0F);
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      if (rises >= 7) hit = 1;
    end
    if (!hit) chk("rise7_timeout", 0, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_cs", {31'd0, cs}, 1);
    chk("async_rst_sclk", {31'd0, sclk}, 1);
    sb.delete();
    repeat (4) @(negedge clock);
    chk("rst_mid_valid", {31'd0, dout_valid}, 0);
    resetn = 1'b1;
    repeat (100) @(negedge clock);
    chk("rst_mid_no_frame", sb.size(), 0);
    chk("rst_mid_dout", {20'd0, dout}, 0);
    single_shot(16'h0ABC);
    chk("post_rst_dout", {20'd0, dout}, 32'hABC);

    repeat (10) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
